serial_adder_ctrl: RTL and testbench

- Bit-serial adder controller. One shared 1-bit full-adder cell adds two WIDTH-bit operands, LSB first, one bit per clock.
- The cell is built from two `half_adder` instances plus an OR for carry-out.
- The block owns the operand shift registers, the carry flop, the bit counter, and valid/ready handshakes on both input and output.
- It is the area-minimal adder for low-rate arithmetic paths.

---
 rtl/serial_adder_ctrl.sv | 166 ++++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial adder: one shared full-adder cell (two half adders plus an OR)
//   adds two WIDTH-bit operands LSB first, one bit per clock. Operands are
//   accepted with a valid/ready handshake and the result is offered with a
//   valid/ready handshake; one operation is in flight at a time.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active high
//   in_valid   operand request
//   in_ready   block can accept operands (IDLE and not in reset)
//   a, b       operands, WIDTH bits
//   cin        carry-in
//   out_valid  result available (registered)
//   out_ready  consumer takes result
//   sum        result, WIDTH bits (registered)
//   cout       final carry-out (registered)
//   busy       operation in progress or result waiting
// -----------------------------------------------------------------------------

module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] sa_r;
    logic [WIDTH-1:0] sb_r;
    logic [WIDTH-1:0] sum_r;
    logic [CNT_W-1:0] cnt_r;
    logic             carry_r;
    logic             cout_r;
    logic             out_valid_r;

    logic             prop_s;
    logic             gen0_s;
    logic             gen1_s;
    logic             bit_sum_s;
    logic             carry_next_s;
    logic [WIDTH-1:0] sum_shift_s;

    // Shared full-adder cell: first half adder combines the operand bits,
    // second folds in the running carry.
    half_adder u_ha_op (
        .a (sa_r[0]),
        .b (sb_r[0]),
        .s (prop_s),
        .c (gen0_s)
    );

    half_adder u_ha_carry (
        .a (prop_s),
        .b (carry_r),
        .s (bit_sum_s),
        .c (gen1_s)
    );

    assign carry_next_s = gen0_s | gen1_s;

    // New sum bit enters at the MSB so that after WIDTH shifts the first
    // (LSB) bit has travelled down to bit 0.
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign sum_shift_s = bit_sum_s;
        end else begin : g_sum_wn
            assign sum_shift_s = {bit_sum_s, sum_r[WIDTH-1:1]};
        end
    endgenerate

    assign in_ready  = (state_r == ST_IDLE) & ~rst;
    assign busy      = (state_r != ST_IDLE);
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;

    // Controller FSM with operand shifters, carry flop, bit counter and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            sa_r        <= {WIDTH{1'b0}};
            sb_r        <= {WIDTH{1'b0}};
            sum_r       <= {WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            carry_r     <= 1'b0;
            cout_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        sa_r    <= a;
                        sb_r    <= b;
                        carry_r <= cin;
                        cnt_r   <= {CNT_W{1'b0}};
                        sum_r   <= {WIDTH{1'b0}};
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    sa_r    <= sa_r >> 1'b1;
                    sb_r    <= sb_r >> 1'b1;
                    sum_r   <= sum_shift_s;
                    carry_r <= carry_next_s;
                    // Counter holds on the final bit so it never exceeds WIDTH-1.
                    if (cnt_r == LAST_CNT) begin
                        state_r     <= ST_DONE;
                        cout_r      <= carry_next_s;
                        out_valid_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
//   Three instances (WIDTH = 1, 8, 13) checked every cycle against a
//   transaction-level model, plus directed operations with literal results.
// -----------------------------------------------------------------------------

module tb_serial_adder_ctrl;

    int wv [3] = '{1, 8, 13};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    logic        iv   [3];
    logic        ordy [3];
    logic        ci   [3];
    logic [63:0] av   [3];
    logic [63:0] bv   [3];

    wire ir [3];
    wire ov [3];
    wire co [3];
    wire bs [3];
    wire [0:0]  sum0;
    wire [7:0]  sum1;
    wire [12:0] sum2;
    wire [63:0] sm [3];

    assign sm[0] = {63'd0, sum0};
    assign sm[1] = {56'd0, sum1};
    assign sm[2] = {51'd0, sum2};

    int n_cmp = 0;
    int n_err = 0;

    // transaction-level model state
    bit          m_active [3] = '{0, 0, 0};
    int          m_age    [3] = '{0, 0, 0};
    logic [63:0] m_res    [3] = '{64'd0, 64'd0, 64'd0};
    logic [63:0] m_sum    [3] = '{64'd0, 64'd0, 64'd0};
    logic        m_cout   [3] = '{1'b0, 1'b0, 1'b0};
    int          m_done   [3] = '{0, 0, 0};

    serial_adder_ctrl #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(av[0][0:0]), .b(bv[0][0:0]), .cin(ci[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sum0), .cout(co[0]), .busy(bs[0])
    );

    serial_adder_ctrl #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(av[1][7:0]), .b(bv[1][7:0]), .cin(ci[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sum1), .cout(co[1]), .busy(bs[1])
    );

    serial_adder_ctrl #(.WIDTH(13)) u_w13 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(av[2][12:0]), .b(bv[2][12:0]), .cin(ci[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .sum(sum2), .cout(co[2]), .busy(bs[2])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, int k, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (width %0d) at cycle %0d: actual=%0h expected=%0h",
                     name, wv[k], cyc, act, exp);
        end
    endtask

    // Model: an accepted operation shows its result W cycles after acceptance
    // and stays until the output handshake.
    always @(posedge clk or posedge rst) begin
        logic [63:0] mk;
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                m_active[k] = 1'b0;
                m_age[k]    = 0;
                m_sum[k]    = 64'd0;
                m_cout[k]   = 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                mk = (64'd1 << wv[k]) - 64'd1;
                if (!m_active[k]) begin
                    if (iv[k]) begin
                        m_active[k] = 1'b1;
                        m_age[k]    = 0;
                        m_res[k]    = (av[k] & mk) + (bv[k] & mk) + {63'd0, ci[k]};
                    end
                end else if (m_age[k] < wv[k]) begin
                    m_age[k]++;
                    if (m_age[k] == wv[k]) begin
                        m_sum[k]  = m_res[k] & mk;
                        m_cout[k] = m_res[k][wv[k]];
                    end
                end else if (ordy[k]) begin
                    m_active[k] = 1'b0;
                    m_done[k]++;
                end
            end
        end
    end

    // Per-cycle comparison of every instance against the model.
    always @(posedge clk) begin
        #3;
        for (int k = 0; k < 3; k++) begin
            check("in_ready", k, {63'd0, ir[k]}, {63'd0, (!m_active[k] && !rst)});
            check("busy", k, {63'd0, bs[k]}, {63'd0, m_active[k]});
            check("out_valid", k, {63'd0, ov[k]}, {63'd0, (m_active[k] && m_age[k] == wv[k])});
            check("cout", k, {63'd0, co[k]}, {63'd0, m_cout[k]});
            if (!m_active[k] || m_age[k] == wv[k])
                check("sum", k, sm[k], m_sum[k]);
            check("ready_busy_excl", k, {63'd0, (ir[k] & bs[k])}, 64'd0);
        end
    end

    // Waits (from a negedge with in_valid high) for the accept edge.
    task automatic wait_accept(int k, output int acc);
        bit ok = 1'b0;
        acc = 0;
        for (int i = 0; i < 200; i++) begin
            if (ir[k]) begin
                @(posedge clk);
                #1;
                acc = cyc;
                ok  = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("accept_timeout", k, {63'd0, ok}, 64'd1);
    endtask

    // Waits at negedges for out_valid; returns the cycle it was seen.
    task automatic wait_valid(int k, output int vc);
        bit ok = 1'b0;
        vc = 0;
        for (int i = 0; i < 200; i++) begin
            if (ov[k]) begin
                vc = cyc;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("valid_timeout", k, {63'd0, ok}, 64'd1);
    endtask

    task automatic run_op(int k, logic [63:0] a, logic [63:0] b, logic c,
                          logic [63:0] es, logic ec, int elat);
        int acc;
        int vc;
        @(negedge clk);
        iv[k] = 1'b1; av[k] = a; bv[k] = b; ci[k] = c; ordy[k] = 1'b1;
        wait_accept(k, acc);
        @(negedge clk);
        iv[k] = 1'b0;
        av[k] = {$urandom(), $urandom()};
        bv[k] = {$urandom(), $urandom()};
        ci[k] = ~c;
        wait_valid(k, vc);
        check("latency", k, 64'(vc - acc), 64'(elat));
        check("sum_lit", k, sm[k], es);
        check("cout_lit", k, {63'd0, co[k]}, {63'd0, ec});
    endtask

    task automatic rand_run(int k, int nops);
        int base = m_done[k];
        int guard = 0;
        while ((m_done[k] - base) < nops && guard < 30000) begin
            @(negedge clk);
            iv[k]   = ($urandom_range(0, 3) != 0);
            av[k]   = {$urandom(), $urandom()};
            bv[k]   = {$urandom(), $urandom()};
            ci[k]   = 1'($urandom_range(0, 1));
            ordy[k] = ($urandom_range(0, 3) != 0);
            guard++;
        end
        check("random_ops_done", k, {63'd0, ((m_done[k] - base) >= nops)}, 64'd1);
        @(negedge clk);
        iv[k]   = 1'b0;
        ordy[k] = 1'b1;
    endtask

    logic [1:0] fa_tab [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    initial begin
        int acc1;
        int acc2;
        int vc;
        int hs;
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b0; ci[k] = 1'b0; av[k] = 64'd0; bv[k] = 64'd0;
        end
        #2;
        for (int k = 0; k < 3; k++) begin
            check("rst_out_valid", k, {63'd0, ov[k]}, 64'd0);
            check("rst_in_ready", k, {63'd0, ir[k]}, 64'd0);
            check("rst_sum", k, sm[k], 64'd0);
            check("rst_busy", k, {63'd0, bs[k]}, 64'd0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", 1, {63'd0, ir[1]}, 64'd1);

        // WIDTH=1 full-adder truth table, index = {a,b,cin}
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            logic [1:0] e;
            v = i[2:0];
            e = fa_tab[i];
            run_op(0, {63'd0, v[2]}, {63'd0, v[1]}, v[0], {63'd0, e[0]}, e[1], 1);
        end

        // WIDTH=8 directed
        run_op(1, 64'hFF, 64'h01, 1'b0, 64'h00, 1'b1, 8);
        run_op(1, 64'h5A, 64'hA5, 1'b1, 64'h00, 1'b1, 8);
        run_op(1, 64'h3C, 64'h42, 1'b0, 64'h7E, 1'b0, 8);
        run_op(2, 64'h1FFF, 64'h0001, 1'b0, 64'h0000, 1'b1, 13);

        // Back-to-back with in_valid and out_ready held high
        @(negedge clk);
        iv[1] = 1'b1; ordy[1] = 1'b1; av[1] = 64'h01; bv[1] = 64'h01; ci[1] = 1'b0;
        wait_accept(1, acc1);
        @(negedge clk);
        av[1] = 64'h80; bv[1] = 64'h80;
        wait_valid(1, vc);
        check("b2b_sum0", 1, sm[1], 64'h02);
        check("b2b_cout0", 1, {63'd0, co[1]}, 64'd0);
        wait_accept(1, acc2);
        check("b2b_spacing", 1, 64'(acc2 - acc1), 64'd10);
        @(negedge clk);
        iv[1] = 1'b0;
        wait_valid(1, vc);
        check("b2b_sum1", 1, sm[1], 64'h00);
        check("b2b_cout1", 1, {63'd0, co[1]}, 64'd1);

        // Backpressure in DONE with new operands pending
        @(negedge clk);
        iv[1] = 1'b1; ordy[1] = 1'b0; av[1] = 64'h3C; bv[1] = 64'h42; ci[1] = 1'b0;
        wait_accept(1, acc1);
        @(negedge clk);
        av[1] = 64'h11; bv[1] = 64'h22; ci[1] = 1'b1;
        wait_valid(1, vc);
        check("bp_latency", 1, 64'(vc - acc1), 64'd8);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 1, {63'd0, ov[1]}, 64'd1);
            check("bp_in_ready", 1, {63'd0, ir[1]}, 64'd0);
            check("bp_sum", 1, sm[1], 64'h7E);
            check("bp_cout", 1, {63'd0, co[1]}, 64'd0);
        end
        ordy[1] = 1'b1;
        @(posedge clk);
        #1;
        hs = cyc;
        @(negedge clk);
        wait_accept(1, acc2);
        check("bp_accept_gap", 1, 64'(acc2 - hs), 64'd1);
        @(negedge clk);
        iv[1] = 1'b0;
        wait_valid(1, vc);
        check("bp_sum2", 1, sm[1], 64'h34);
        check("bp_cout2", 1, {63'd0, co[1]}, 64'd0);

        // Reset in the middle of RUN
        @(negedge clk);
        iv[1] = 1'b1; av[1] = 64'hFF; bv[1] = 64'hFF; ci[1] = 1'b0;
        wait_accept(1, acc1);
        @(negedge clk);
        iv[1] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 1, {63'd0, ov[1]}, 64'd0);
        check("midrst_sum", 1, sm[1], 64'd0);
        check("midrst_cout", 1, {63'd0, co[1]}, 64'd0);
        check("midrst_busy", 1, {63'd0, bs[1]}, 64'd0);
        check("midrst_in_ready", 1, {63'd0, ir[1]}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_op(1, 64'h10, 64'h20, 1'b0, 64'h30, 1'b0, 8);

        // Random regression with stalls, all widths in parallel
        fork
            rand_run(0, 300);
            rand_run(1, 1000);
            rand_run(2, 1000);
        join

        repeat (20) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
